hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core, on the consuming end of the ID/EX register. It observes the IF/ID source fields and the ID/EX and EX/MEM control/address outputs. It drives the write-enable, bubble and flush inputs of PC, IF/ID, ID/EX and EX/MEM. Sequential behaviour comes from a data-memory wait FSM with timeout and from saturating performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 14 +
 rtl/hazard_ctrl_if.sv | 48 ++++
 rtl/hazard_cmp.sv | 16 +
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: register address
// width, the zero register and the memory-wait FSM state encoding.
package hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller; the pipeline drives
// the observed fields (master), the controller drives the enables (slave).
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned FLUSH_W = 16
);
  import hazard_ctrl_pkg::*;

  logic [REG_AW-1:0]  IFID_RSaddr_i;
  logic [REG_AW-1:0]  IFID_RTaddr_i;
  logic               Branch_i;
  logic               BranchTaken_i;
  logic               IDEX_MemRead_i;
  logic               IDEX_RegWrite_i;
  logic [REG_AW-1:0]  IDEX_RDaddr_i;
  logic               EXMEM_MemRead_i;
  logic [REG_AW-1:0]  EXMEM_RDaddr_i;
  logic               mem_req_i;
  logic               mem_ready_i;

  logic               PCWrite_o;
  logic               IFIDWrite_o;
  logic               IFIDFlush_o;
  logic               IDEXWrite_o;
  logic               IDEXBubble_o;
  logic               EXMEMHold_o;
  logic               mem_err_o;
  logic [CNT_W-1:0]   stall_cnt_o;
  logic [FLUSH_W-1:0] flush_cnt_o;
  logic [1:0]         state_o;

  modport master (
    output IFID_RSaddr_i, IFID_RTaddr_i, Branch_i, BranchTaken_i,
           IDEX_MemRead_i, IDEX_RegWrite_i, IDEX_RDaddr_i,
           EXMEM_MemRead_i, EXMEM_RDaddr_i, mem_req_i, mem_ready_i,
    input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXWrite_o, IDEXBubble_o,
           EXMEMHold_o, mem_err_o, stall_cnt_o, flush_cnt_o, state_o
  );

  modport slave (
    input  IFID_RSaddr_i, IFID_RTaddr_i, Branch_i, BranchTaken_i,
           IDEX_MemRead_i, IDEX_RegWrite_i, IDEX_RDaddr_i,
           EXMEM_MemRead_i, EXMEM_RDaddr_i, mem_req_i, mem_ready_i,
    output PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXWrite_o, IDEXBubble_o,
           EXMEMHold_o, mem_err_o, stall_cnt_o, flush_cnt_o, state_o
  );

endinterface

// File: rtl/hazard_cmp.sv
// Qualified destination-vs-source match; register 0 never produces a hit.
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic              en,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  output logic              hit
);

  always_comb begin
    hit = en && (rd != REG_ZERO) && ((rd == rs) || (rd == rt));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use / branch-operand stalls, taken-branch flush,
// data-memory wait FSM with sticky timeout, saturating stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned FLUSH_W     = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned TW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TW-1:0]      T_MAX     = TW'(MEM_TIMEOUT - 1);
  localparam logic [TW-1:0]      T_ERR_PRE = TW'(MEM_TIMEOUT - 2);
  localparam logic [TW-1:0]      T_ONE     = TW'(1);
  localparam logic [CNT_W-1:0]   S_ONE     = CNT_W'(1);
  localparam logic [FLUSH_W-1:0] F_ONE     = FLUSH_W'(1);

  hz_state_e          state;
  logic [TW-1:0]      tcnt;
  logic               mem_err;
  logic [CNT_W-1:0]   stall_cnt;
  logic [FLUSH_W-1:0] flush_cnt;

  logic lu, bx, bm, stall, freeze;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_hold;

  hazard_cmp u_cmp_lu (
    .en  (hz.IDEX_MemRead_i),
    .rd  (hz.IDEX_RDaddr_i),
    .rs  (hz.IFID_RSaddr_i),
    .rt  (hz.IFID_RTaddr_i),
    .hit (lu)
  );

  hazard_cmp u_cmp_bx (
    .en  (hz.Branch_i && hz.IDEX_RegWrite_i),
    .rd  (hz.IDEX_RDaddr_i),
    .rs  (hz.IFID_RSaddr_i),
    .rt  (hz.IFID_RTaddr_i),
    .hit (bx)
  );

  hazard_cmp u_cmp_bm (
    .en  (hz.Branch_i && hz.EXMEM_MemRead_i),
    .rd  (hz.EXMEM_RDaddr_i),
    .rs  (hz.IFID_RSaddr_i),
    .rt  (hz.IFID_RTaddr_i),
    .hit (bm)
  );

  always_comb begin
    stall  = lu || bx || bm;
    freeze = (state == MEM_WAIT) || (hz.mem_req_i && !hz.mem_ready_i);
  end

  // Priority: memory freeze, then hazard bubble, then taken-branch flush.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_we     = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    if (rst_i) begin
      if (freeze) begin
        exmem_hold = 1'b1;
      end else if (stall) begin
        idex_we     = 1'b1;
        idex_bubble = 1'b1;
      end else begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        idex_we    = 1'b1;
        ifid_flush = hz.BranchTaken_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= RUN;
      tcnt      <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we && (stall_cnt != '1)) stall_cnt <= stall_cnt + S_ONE;
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + F_ONE;
      case (state)
        RUN: begin
          if (hz.mem_req_i && !hz.mem_ready_i) begin
            state <= MEM_WAIT;
            tcnt  <= '0;
          end
        end
        MEM_WAIT: begin
          if (hz.mem_ready_i) begin
            state <= RUN;
            tcnt  <= '0;
          end else begin
            if (tcnt != T_MAX) tcnt <= tcnt + T_ONE;
            // Flag raised on the edge where the count reaches MEM_TIMEOUT-1.
            if (tcnt == T_ERR_PRE) mem_err <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    hz.PCWrite_o    = pc_we;
    hz.IFIDWrite_o  = ifid_we;
    hz.IFIDFlush_o  = ifid_flush;
    hz.IDEXWrite_o  = idex_we;
    hz.IDEXBubble_o = idex_bubble;
    hz.EXMEMHold_o  = exmem_hold;
    hz.mem_err_o    = mem_err;
    hz.stall_cnt_o  = stall_cnt;
    hz.flush_cnt_o  = flush_cnt;
    hz.state_o      = state;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  localparam logic [5:0] C_RST    = 6'b000000;
  localparam logic [5:0] C_RUN    = 6'b110100;
  localparam logic [5:0] C_STALL  = 6'b000110;
  localparam logic [5:0] C_FLUSH  = 6'b111100;
  localparam logic [5:0] C_FREEZE = 6'b000001;

  typedef struct {
    int unsigned id;
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic        err;
    logic [31:0] sc;
    logic [3:0]  fc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int unsigned vec_id;
  exp_t exp_q[$];

  hazard_ctrl_if #(.CNT_W(32), .FLUSH_W(4)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32), .FLUSH_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] ctl_now();
    return {hz.PCWrite_o, hz.IFIDWrite_o, hz.IFIDFlush_o,
            hz.IDEXWrite_o, hz.IDEXBubble_o, hz.EXMEMHold_o};
  endfunction

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (ctl_now() !== e.ctl || hz.state_o !== e.st || hz.mem_err_o !== e.err ||
            hz.stall_cnt_o !== e.sc || hz.flush_cnt_o !== e.fc) begin
          n_bad++;
          $display("FAIL vec%0d: got ctl=%b st=%0d err=%b sc=%0d fc=%0d, want ctl=%b st=%0d err=%b sc=%0d fc=%0d",
                   e.id, ctl_now(), hz.state_o, hz.mem_err_o, hz.stall_cnt_o, hz.flush_cnt_o,
                   e.ctl, e.st, e.err, e.sc, e.fc);
        end
      end
    end
  end

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic br,
                        input logic bt, input logic imr, input logic irw,
                        input logic [4:0] ird, input logic emr, input logic [4:0] erd,
                        input logic req, input logic rdy);
    hz.IFID_RSaddr_i   = rs;
    hz.IFID_RTaddr_i   = rt;
    hz.Branch_i        = br;
    hz.BranchTaken_i   = bt;
    hz.IDEX_MemRead_i  = imr;
    hz.IDEX_RegWrite_i = irw;
    hz.IDEX_RDaddr_i   = ird;
    hz.EXMEM_MemRead_i = emr;
    hz.EXMEM_RDaddr_i  = erd;
    hz.mem_req_i       = req;
    hz.mem_ready_i     = rdy;
  endtask

  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic br,
                      input logic bt, input logic imr, input logic irw,
                      input logic [4:0] ird, input logic emr, input logic [4:0] erd,
                      input logic req, input logic rdy,
                      input logic [5:0] ctl, input logic [1:0] st, input logic err,
                      input logic [31:0] sc, input logic [3:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    set_in(rs, rt, br, bt, imr, irw, ird, emr, erd, req, rdy);
    vec_id++;
    e.id = vec_id; e.ctl = ctl; e.st = st; e.err = err; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [1:0] st, input logic err, input logic [31:0] sc,
                      input logic [3:0] fc);
    step(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0, C_RUN, st, err, sc, fc);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    vec_id = 0;
    rst_n  = 1'b0;
    set_in(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    #3;
    chk("reset_ctl", 64'(ctl_now()), 64'(C_RST));
    chk("reset_state", 64'(hz.state_o), 64'd0);
    chk("reset_cnt", {hz.stall_cnt_o, 28'd0, hz.flush_cnt_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    idle(2'd0, 0, 32'd0, 4'd0);
    // load-use on rs
    step(5'd2, 5'd0, 0, 0, 1, 1, 5'd2, 0, 5'd0, 0, 0, C_STALL, 2'd0, 0, 32'd0, 4'd0);
    idle(2'd0, 0, 32'd1, 4'd0);
    // load $3 then beq on rt=3: lu/bx then bm
    step(5'd0, 5'd3, 1, 0, 1, 1, 5'd3, 0, 5'd0, 0, 0, C_STALL, 2'd0, 0, 32'd1, 4'd0);
    step(5'd0, 5'd3, 1, 0, 0, 0, 5'd0, 1, 5'd3, 0, 0, C_STALL, 2'd0, 0, 32'd2, 4'd0);
    idle(2'd0, 0, 32'd3, 4'd0);
    // destination register 0 never matches, even against rs=0
    step(5'd0, 5'd3, 1, 0, 1, 1, 5'd0, 0, 5'd0, 0, 0, C_RUN, 2'd0, 0, 32'd3, 4'd0);
    step(5'd0, 5'd3, 1, 0, 0, 0, 5'd0, 1, 5'd0, 0, 0, C_RUN, 2'd0, 0, 32'd3, 4'd0);
    // branch on ALU result in EX
    step(5'd5, 5'd0, 1, 0, 0, 1, 5'd5, 0, 5'd0, 0, 0, C_STALL, 2'd0, 0, 32'd3, 4'd0);
    // taken branch, no hazard
    step(5'd1, 5'd2, 1, 1, 0, 1, 5'd7, 0, 5'd0, 0, 0, C_FLUSH, 2'd0, 0, 32'd4, 4'd0);
    idle(2'd0, 0, 32'd4, 4'd1);
    // taken branch with load-use: bubble wins, no flush
    step(5'd4, 5'd0, 1, 1, 1, 1, 5'd4, 0, 5'd0, 0, 0, C_STALL, 2'd0, 0, 32'd4, 4'd1);
    idle(2'd0, 0, 32'd5, 4'd1);
    // request with ready in the same cycle
    step(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 1, C_RUN, 2'd0, 0, 32'd5, 4'd1);
    // 3 cycles not ready then ready: 4 frozen cycles
    step(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 0, C_FREEZE, 2'd0, 0, 32'd5, 4'd1);
    step(5'd6, 5'd0, 0, 0, 1, 1, 5'd6, 0, 5'd0, 1, 0, C_FREEZE, 2'd1, 0, 32'd6, 4'd1);
    step(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 0, C_FREEZE, 2'd1, 0, 32'd7, 4'd1);
    step(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 1, C_FREEZE, 2'd1, 0, 32'd8, 4'd1);
    idle(2'd0, 0, 32'd9, 4'd1);
    // timeout: error visible after the 16th frozen edge, then sticky
    step(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 0, C_FREEZE, 2'd0, 0, 32'd9, 4'd1);
    for (int k = 1; k <= 17; k++) begin
      step(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 0, C_FREEZE, 2'd1, (k >= 16),
           32'(9 + k), 4'd1);
    end

    // asynchronous reset in the middle of MEM_WAIT
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 64'(hz.state_o), 64'd0);
    chk("async_rst_err", 64'(hz.mem_err_o), 64'd0);
    chk("async_rst_ctl", 64'(ctl_now()), 64'(C_RST));
    chk("async_rst_cnt", {hz.stall_cnt_o, 28'd0, hz.flush_cnt_o}, 64'd0);
    set_in(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2'd0, 0, 32'd0, 4'd0);

    // flush counter saturation (4-bit instance)
    for (int i = 0; i < 20; i++) begin
      step(5'd1, 5'd2, 1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 0, C_FLUSH, 2'd0, 0, 32'd0,
           (i > 15) ? 4'd15 : 4'(i));
    end
    idle(2'd0, 0, 32'd0, 4'd15);

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected records never checked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
